// File: rtl/router_pkg.sv
// Shared widths, header field positions, FSM encoding and helpers for the
// router output-port packet sink.
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;
  localparam int TMR_W  = 8;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_HDR_ENC  = 2'd1;
  localparam logic [1:0] ST_BODY_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_HDR  = ST_HDR_ENC,
    ST_BODY = ST_BODY_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction
endpackage

// File: rtl/router_sink_timer.sv
// Mid-packet stall counter: expire_o is high during the TIMEOUT-th consecutive
// stalled cycle; the count restarts on clear or on expiry.
module router_sink_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);
  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Expiry fires on the stalled cycle that completes the budget.
  always_comb begin
    expire_o = inc_i & ~clr_i & (cnt_q == TMR_W'(TIMEOUT - 1));
    if (clr_i || expire_o) begin
      cnt_d = {TMR_W{1'b0}};
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {TMR_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/router_port_sink.sv
// Consumer side of one router output-port FIFO: pops a whole packet, streams
// its payload, and reports length, address, parity, address and timeout status.
module router_port_sink
  import router_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PORT_ADDR = 2'd0,
  parameter int                TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] d_out,
  input  logic              sink_en,
  output logic              rd_en,
  output logic              byte_vld,
  output logic [DATA_W-1:0] byte_data,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic              parity_err,
  output logic              addr_err,
  output logic              trunc_err
);
  state_t              state_q, state_d;
  logic [LEN_W:0]      rem_q, rem_d;
  logic [LEN_W:0]      ret_q, ret_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                pend_q, pend_d;
  logic                byte_vld_q, byte_vld_d;
  logic [DATA_W-1:0]   byte_data_q, byte_data_d;
  logic                pkt_done_q, pkt_done_d;
  logic [LEN_W-1:0]    pkt_len_q, pkt_len_d;
  logic [ADDR_W-1:0]   pkt_addr_q, pkt_addr_d;
  logic                parity_err_q, parity_err_d;
  logic                addr_err_q, addr_err_d;
  logic                trunc_err_q, trunc_err_d;
  logic                rd_en_s;
  logic                tmr_clr_s;
  logic                tmr_inc_s;
  logic                tmr_expire_s;

  router_sink_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr_s),
    .inc_i    (tmr_inc_s),
    .expire_o (tmr_expire_s)
  );

  // pend_q marks that d_out carries the byte popped in the previous cycle.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    ret_d        = ret_q;
    len_d        = len_q;
    addr_d       = addr_q;
    acc_d        = acc_q;
    pend_d       = 1'b0;
    byte_vld_d   = 1'b0;
    byte_data_d  = byte_data_q;
    pkt_done_d   = 1'b0;
    pkt_len_d    = pkt_len_q;
    pkt_addr_d   = pkt_addr_q;
    parity_err_d = parity_err_q;
    addr_err_d   = addr_err_q;
    trunc_err_d  = 1'b0;
    rd_en_s      = 1'b0;
    tmr_clr_s    = 1'b1;
    tmr_inc_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_en_s = vld_out & sink_en & ~rst;
        if (rd_en_s) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        len_d   = hdr_len(d_out);
        addr_d  = hdr_addr(d_out);
        rem_d   = {1'b0, hdr_len(d_out)} + 7'd1;
        ret_d   = 7'd0;
        acc_d   = d_out;
        state_d = ST_BODY;
      end
      ST_BODY: begin
        rd_en_s   = vld_out & sink_en & (rem_q != 7'd0);
        tmr_inc_s = sink_en & ~vld_out & (rem_q != 7'd0);
        tmr_clr_s = rd_en_s | ~sink_en;
        if (rd_en_s) begin
          rem_d  = rem_q - 7'd1;
          pend_d = 1'b1;
        end else begin
          rem_d  = rem_q;
          pend_d = 1'b0;
        end
        if (pend_q) begin
          acc_d = acc_q ^ d_out;
          ret_d = ret_q + 7'd1;
          // The byte after the L payload bytes is the parity byte.
          if (ret_q == {1'b0, len_q}) begin
            pkt_done_d   = 1'b1;
            pkt_len_d    = len_q;
            pkt_addr_d   = addr_q;
            parity_err_d = ((acc_q ^ d_out) != 8'd0);
            addr_err_d   = (addr_q != PORT_ADDR);
            state_d      = ST_DONE;
          end else begin
            byte_vld_d  = 1'b1;
            byte_data_d = d_out;
            state_d     = ST_BODY;
          end
        end else if (tmr_expire_s) begin
          trunc_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_BODY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, packet context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= 7'd0;
      ret_q        <= 7'd0;
      len_q        <= 6'd0;
      addr_q       <= 2'd0;
      acc_q        <= 8'd0;
      pend_q       <= 1'b0;
      byte_vld_q   <= 1'b0;
      byte_data_q  <= 8'd0;
      pkt_done_q   <= 1'b0;
      pkt_len_q    <= 6'd0;
      pkt_addr_q   <= 2'd0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      trunc_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      ret_q        <= ret_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      acc_q        <= acc_d;
      pend_q       <= pend_d;
      byte_vld_q   <= byte_vld_d;
      byte_data_q  <= byte_data_d;
      pkt_done_q   <= pkt_done_d;
      pkt_len_q    <= pkt_len_d;
      pkt_addr_q   <= pkt_addr_d;
      parity_err_q <= parity_err_d;
      addr_err_q   <= addr_err_d;
      trunc_err_q  <= trunc_err_d;
    end
  end

  assign rd_en      = rd_en_s;
  assign byte_vld   = byte_vld_q;
  assign byte_data  = byte_data_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_addr   = pkt_addr_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign trunc_err  = trunc_err_q;
endmodule

// File: tb/tb_router_port_sink.sv
// Directed bench for router_port_sink: a queue models the port FIFO, and
// expected payload bytes and completion records are scoreboarded.
module tb_router_port_sink;
  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
    logic       perr;
    logic       aerr;
  } done_t;

  logic       clk = 1'b0;
  logic       rst, vld_out, sink_en, rd_en, byte_vld, pkt_done;
  logic       parity_err, addr_err, trunc_err;
  logic [7:0] d_out, byte_data;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;

  int tests = 0, fails = 0;
  int pops = 0, byte_cnt = 0, done_cnt = 0, trunc_cnt = 0, done_pops = 0;
  int stall_cnt = 0, stall_at_trunc = -1;
  bit stall_mon = 1'b0;
  logic [7:0] fifo[$];
  logic [7:0] exp_bytes[$];
  done_t      exp_done[$];
  logic [7:0] pl[64];

  always #5 clk = ~clk;

  router_port_sink #(.PORT_ADDR(2'd2), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .vld_out    (vld_out),
    .d_out      (d_out),
    .sink_en    (sink_en),
    .rd_en      (rd_en),
    .byte_vld   (byte_vld),
    .byte_data  (byte_data),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .pkt_addr   (pkt_addr),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .trunc_err  (trunc_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample mid-cycle, then emulate the FIFO pop after the edge.
  task automatic step();
    logic       popped;
    logic [7:0] eb;
    done_t      e;
    #1;
    popped = rd_en;
    if (popped) pops++;
    if (stall_mon) begin
      if (trunc_err) stall_at_trunc = stall_cnt;
      if (popped) stall_cnt = 0;
      else if (!vld_out && sink_en) stall_cnt++;
    end
    if (byte_vld) begin
      byte_cnt++;
      chk("byte_pending", 32'(exp_bytes.size() != 0), 32'd1);
      if (exp_bytes.size() != 0) begin
        eb = exp_bytes.pop_front();
        chk("byte_data", 32'(byte_data), 32'(eb));
      end
    end
    if (pkt_done) begin
      done_cnt++;
      done_pops = pops;
      chk("done_pending", 32'(exp_done.size() != 0), 32'd1);
      if (exp_done.size() != 0) begin
        e = exp_done.pop_front();
        chk("pkt_len", 32'(pkt_len), 32'(e.len));
        chk("pkt_addr", 32'(pkt_addr), 32'(e.addr));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
        chk("addr_err", 32'(addr_err), 32'(e.aerr));
      end
    end
    if (trunc_err) trunc_cnt++;
    @(posedge clk);
    #1;
    if (popped) d_out = fifo.pop_front();
    vld_out = (fifo.size() > 0);
    @(negedge clk);
  endtask

  // Queue header, up to keep payload bytes from pl[], and the parity byte if complete.
  task automatic push_pkt(input logic [5:0] len, input logic [1:0] addr,
                          input logic [7:0] mask, input int keep);
    logic [7:0] hdr, p;
    done_t      e;
    hdr = {len, addr};
    p   = hdr;
    fifo.push_back(hdr);
    for (int i = 0; i < int'(len); i++) begin
      p = p ^ pl[i];
      if (i < keep) begin
        fifo.push_back(pl[i]);
        exp_bytes.push_back(pl[i]);
      end
    end
    if (keep > int'(len)) begin
      fifo.push_back(p ^ mask);
      e.len  = len;
      e.addr = addr;
      e.perr = (mask != 8'd0);
      e.aerr = (addr != 2'd2);
      exp_done.push_back(e);
    end
    vld_out = (fifo.size() > 0);
  endtask

  task automatic run_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int p0, b0, d0, t0, n;
    rst = 1'b1; vld_out = 1'b0; sink_en = 1'b1; d_out = 8'd0;
    @(negedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_byte_vld", 32'(byte_vld), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_pkt_len", 32'(pkt_len), 32'd0);
    chk("rst_pkt_addr", 32'(pkt_addr), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_trunc_err", 32'(trunc_err), 32'd0);
    vld_out = 1'b1;
    #1;
    chk("rst_rd_en_vld_high", 32'(rd_en), 32'd0);
    vld_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Header 8'h3A: L = 14, addr = 2, good parity.
    fill_random();
    p0 = pops; b0 = byte_cnt; d0 = done_cnt;
    push_pkt(6'd14, 2'd2, 8'h00, 64);
    run_done(d0 + 1, 100);
    chk("p1_pops", 32'(pops - p0), 32'd16);
    chk("p1_bytes", 32'(byte_cnt - b0), 32'd14);
    step();
    chk("p1_done_single", 32'(done_cnt - d0), 32'd1);
    chk("p1_len_hold", 32'(pkt_len), 32'd14);
    chk("p1_addr_hold", 32'(pkt_addr), 32'd2);

    // Same packet with the parity byte flipped in bit 0.
    p0 = pops; d0 = done_cnt;
    push_pkt(6'd14, 2'd2, 8'h01, 64);
    run_done(d0 + 1, 100);
    chk("p2_pops", 32'(pops - p0), 32'd16);
    chk("p2_parity_hold", 32'(parity_err), 32'd1);

    // Header 8'h01: L = 0, wrong address.
    p0 = pops; b0 = byte_cnt; d0 = done_cnt;
    push_pkt(6'd0, 2'd1, 8'h00, 64);
    run_done(d0 + 1, 40);
    chk("p3_pops", 32'(pops - p0), 32'd2);
    chk("p3_no_bytes", 32'(byte_cnt - b0), 32'd0);
    chk("p3_addr_err_hold", 32'(addr_err), 32'd1);

    // Two packets back to back; first pkt_done lands before the second header pop.
    fill_random();
    p0 = pops; d0 = done_cnt;
    push_pkt(6'd3, 2'd2, 8'h00, 64);
    push_pkt(6'd5, 2'd2, 8'h00, 64);
    run_done(d0 + 1, 60);
    chk("b2b_first_pops", 32'(done_pops - p0), 32'd5);
    run_done(d0 + 2, 60);
    chk("b2b_second_pops", 32'(done_pops - p0), 32'd12);

    // Stall after payload byte 4 of L = 10 until timeout.
    fill_random();
    d0 = done_cnt; t0 = trunc_cnt; b0 = byte_cnt;
    stall_cnt = 0; stall_at_trunc = -1; stall_mon = 1'b1;
    push_pkt(6'd10, 2'd2, 8'h00, 4);
    n = 0;
    while (trunc_cnt == t0 && n < 60) begin
      step();
      n++;
    end
    stall_mon = 1'b0;
    chk("trunc_seen", 32'(trunc_cnt - t0), 32'd1);
    chk("trunc_stall_cycles", 32'(stall_at_trunc), 32'd16);
    repeat (3) step();
    chk("trunc_single_pulse", 32'(trunc_cnt - t0), 32'd1);
    chk("trunc_no_done", 32'(done_cnt - d0), 32'd0);
    chk("trunc_bytes", 32'(byte_cnt - b0), 32'd4);
    chk("trunc_len_hold", 32'(pkt_len), 32'd5);
    fill_random();
    push_pkt(6'd2, 2'd2, 8'h00, 64);
    run_done(d0 + 1, 40);

    // sink_en low for 40 cycles mid-packet: no timeout.
    fill_random();
    d0 = done_cnt; t0 = trunc_cnt; b0 = byte_cnt;
    push_pkt(6'd6, 2'd2, 8'h00, 64);
    n = 0;
    while (byte_cnt < b0 + 2 && n < 20) begin
      step();
      n++;
    end
    sink_en = 1'b0;
    p0 = pops;
    repeat (40) step();
    chk("hold_no_pops", 32'(pops - p0), 32'd0);
    chk("hold_no_trunc", 32'(trunc_cnt - t0), 32'd0);
    sink_en = 1'b1;
    run_done(d0 + 1, 40);
    chk("hold_bytes", 32'(byte_cnt - b0), 32'd6);

    // Reset mid-BODY.
    fill_random();
    b0 = byte_cnt;
    push_pkt(6'd8, 2'd2, 8'h00, 64);
    n = 0;
    while (byte_cnt < b0 + 3 && n < 20) begin
      step();
      n++;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rst_byte_vld", 32'(byte_vld), 32'd0);
    chk("mid_rst_byte_data", 32'(byte_data), 32'd0);
    chk("mid_rst_pkt_len", 32'(pkt_len), 32'd0);
    chk("mid_rst_pkt_addr", 32'(pkt_addr), 32'd0);
    chk("mid_rst_parity_err", 32'(parity_err), 32'd0);
    chk("mid_rst_addr_err", 32'(addr_err), 32'd0);
    fifo.delete();
    exp_bytes.delete();
    exp_done.delete();
    vld_out = 1'b0;
    d0 = done_cnt; t0 = trunc_cnt;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_rst_no_trunc", 32'(trunc_cnt - t0), 32'd0);
    fill_random();
    p0 = pops;
    push_pkt(6'd1, 2'd2, 8'h00, 64);
    run_done(d0 + 1, 40);
    chk("post_rst_pops", 32'(pops - p0), 32'd3);
    chk("post_rst_len", 32'(pkt_len), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
